// File: rtl/stream_argmax_if.sv
// Handshake bundle for stream_argmax: a beat stream of logits in, a held
// {index, max} result out. The DUT attaches through the slave modport.
interface stream_argmax_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 1,
    parameter int IDX_WIDTH  = 4
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*DATA_WIDTH-1:0]   in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [IDX_WIDTH-1:0]          out_idx;
    logic [DATA_WIDTH-1:0]         out_max;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_idx, out_max
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_idx, out_max
    );
endinterface

// File: rtl/stream_argmax.sv
// Streaming argmax: folds a NUM_ARGS-element vector arriving LANES per beat
// into a running max/index and presents the winner on a held result port.
module stream_argmax #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ARGS   = 10,
    parameter int LANES      = 1,
    parameter int SIGNED     = 1,
    parameter int IDX_WIDTH  = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    stream_argmax_if.slave  bus
);
    localparam int NBEATS = (NUM_ARGS + LANES - 1) / LANES;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic {ACCUM, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   max_q, max_d;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;

    logic [DATA_WIDTH-1:0]   lane_data [LANES];
    logic [DATA_WIDTH-1:0]   beat_max;
    logic [IDX_WIDTH-1:0]    beat_idx;
    logic                    accept;
    logic                    last_beat;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_data[gi] = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // Lane 0 always holds a real element; later lanes may be final-beat padding.
    always_comb begin : p_reduce
        int base;
        base     = int'(cnt_q) * LANES;
        beat_max = lane_data[0];
        beat_idx = IDX_WIDTH'(base);
        for (int k = 1; k < LANES; k++) begin
            if ((base + k < NUM_ARGS) && greater(lane_data[k], beat_max)) begin
                beat_max = lane_data[k];
                beat_idx = IDX_WIDTH'(base + k);
            end
        end
    end

    assign accept    = bus.in_valid && (state_q == ACCUM);
    assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        idx_d   = idx_q;
        if (clear) begin
            state_d = ACCUM;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        // Beat 0 seeds the running max, so no sentinel value is needed.
                        if ((cnt_q == '0) || greater(beat_max, max_q)) begin
                            max_d = beat_max;
                            idx_d = beat_idx;
                        end
                        if (last_beat) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
        end
    end

    // The running registers double as the result; nothing is accepted in DONE.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_idx   = idx_q;
    assign bus.out_max   = max_q;
endmodule
